branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal 2-bit branch predictor with a two-stage (D, X) record pipeline and EX-stage repair.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        ex_resolve,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        br_pred_taken,
  output logic        mispredict,
  output logic [31:0] restore_addr
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef struct packed {
    logic             valid;
    logic             taken;
    logic [31:0]      fallthrough;
    logic [IDX_W-1:0] idx;
  } rec_t;

  rec_t             if_rec;
  rec_t             d_rec;
  rec_t             x_rec;
  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] index;
  logic [1:0]       cnt_rd;
  logic             is_branch;
  logic             update;
  logic             unused_inst;

  assign unused_inst = ^inst[31:7];
  assign index       = pc[IDX_W+1:2];
  assign is_branch   = (inst[6:0] == 7'b1100011);
  assign cnt_rd      = bht[index];

  // ex_resolve is a one-cycle strobe with no back-pressure: it only has
  // meaning when X holds a valid branch, otherwise it is ignored entirely.
  assign update        = ex_resolve && x_rec.valid;
  assign mispredict    = update && (x_rec.taken != ex_taken);
  assign br_pred_taken = rst_n && is_branch && cnt_rd[1] && !stall && !mispredict;
  assign restore_addr  = ex_taken ? ex_target : x_rec.fallthrough;

  always_comb begin
    if_rec             = '0;
    if_rec.valid       = is_branch;
    if_rec.taken       = br_pred_taken;
    if_rec.fallthrough = pc + 32'd4;
    if_rec.idx         = index;
  end

  // A flush wins over stall so the wrong-path records never survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rec <= '0;
      x_rec <= '0;
    end else if (mispredict) begin
      d_rec.valid <= 1'b0;
      x_rec.valid <= 1'b0;
    end else if (!stall) begin
      d_rec <= if_rec;
      x_rec <= d_rec;
    end
  end

  // Training ignores stall; lookups this cycle see the pre-update value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
    end else if (update) begin
      if (ex_taken) begin
        if (bht[x_rec.idx] != 2'b11) bht[x_rec.idx] <= bht[x_rec.idx] + 2'd1;
      end else begin
        if (bht[x_rec.idx] != 2'b00) bht[x_rec.idx] <= bht[x_rec.idx] - 2'd1;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (update)     stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic against a
// table-and-records reference model; build with +define+BP_STATS_EN to cover the stats.
module tb_branch_predictor;

  localparam int          BHT = 64;
  localparam logic [31:0] BR  = 32'h0000_0063;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TGT = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;
  logic        ex_resolve = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        br_pred_taken;
  logic        mispredict;
  logic [31:0] restore_addr;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  branch_predictor #(.BHT_ENTRIES(BHT), .CNT_INIT(2'b01)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .pc            (pc),
    .inst          (inst),
    .ex_resolve    (ex_resolve),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .br_pred_taken (br_pred_taken),
    .mispredict    (mispredict),
    .restore_addr  (restore_addr)
`ifdef BP_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: counter table plus the two in-flight branch records
  int          cnt_m [BHT];
  logic        dv, dt, xv, xt;
  logic [31:0] dft, xft;
  int          didx, xidx;
  logic [31:0] sb_m, sm_m;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        res;
    logic        tkn;
    logic [31:0] tgt;
  } step_t;

  step_t       steps [$];
  logic        obs_p [$];
  logic        exp_p [$];
  logic        obs_m [$];
  logic        exp_m [$];
  logic [31:0] obs_r [$];
  logic [31:0] exp_r [$];

  function automatic void add(input logic r, input logic s, input logic [31:0] p,
                              input logic [31:0] i, input logic rs, input logic tk,
                              input logic [31:0] tg);
    steps.push_back('{r, s, p, i, rs, tk, tg});
  endfunction

  function automatic void add_seq(input logic [31:0] p, input logic tk);
    add(1'b0, 1'b0, p, BR, 1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, p + 32'd4, NOP, 1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, p + 32'd8, NOP, 1'b1, tk, TGT);
  endfunction

  function automatic void model_reset();
    foreach (cnt_m[i]) cnt_m[i] = 1;
    dv = 1'b0; dt = 1'b0; dft = '0; didx = 0;
    xv = 1'b0; xt = 1'b0; xft = '0; xidx = 0;
    sb_m = '0; sm_m = '0;
  endfunction

  // driver: plays the step queue, records DUT outputs and model expectations
  task automatic play();
    logic        ep, em, isb;
    logic [31:0] er;
    int          idx;
    obs_p.delete(); exp_p.delete(); obs_m.delete();
    exp_m.delete(); obs_r.delete(); exp_r.delete();
    foreach (steps[k]) begin
      rst_n      = !steps[k].rst;
      stall      = steps[k].stall;
      pc         = steps[k].pc;
      inst       = steps[k].inst;
      ex_resolve = steps[k].res;
      ex_taken   = steps[k].tkn;
      ex_target  = steps[k].tgt;
      if (steps[k].rst) model_reset();
      isb = (steps[k].inst[6:0] == 7'b1100011);
      idx = int'((steps[k].pc >> 2) % 32'(BHT));
      em  = !steps[k].rst && steps[k].res && xv && (xt != steps[k].tkn);
      ep  = !steps[k].rst && isb && (cnt_m[idx] >= 2) && !steps[k].stall && !em;
      er  = steps[k].tkn ? steps[k].tgt : xft;
      exp_p.push_back(ep); exp_m.push_back(em); exp_r.push_back(er);
      @(negedge clk);
      obs_p.push_back(br_pred_taken); obs_m.push_back(mispredict); obs_r.push_back(restore_addr);
      @(posedge clk);
      if (!steps[k].rst) begin
        if (steps[k].res && xv) begin
          sb_m++;
          if (steps[k].tkn) cnt_m[xidx] = (cnt_m[xidx] == 3) ? 3 : cnt_m[xidx] + 1;
          else              cnt_m[xidx] = (cnt_m[xidx] == 0) ? 0 : cnt_m[xidx] - 1;
        end
        if (em) begin
          sm_m++;
          dv = 1'b0;
          xv = 1'b0;
        end else if (!steps[k].stall) begin
          xv = dv; xt = dt; xft = dft; xidx = didx;
          dv = isb; dt = ep; dft = steps[k].pc + 32'd4; didx = idx;
        end
      end
      #1;
    end
    steps.delete();
  endtask

  task automatic test_reset();
    add(1'b1, 1'b0, 32'h4000_0010, BR, 1'b1, 1'b1, TGT);
    add(1'b1, 1'b0, 32'h4000_0010, BR, 1'b1, 1'b0, TGT);
    play();
    for (int k = 0; k < obs_p.size(); k++) begin
      n_total++;
      if (obs_p[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_pred step %0d: got %b want 0", k, obs_p[k]);
      end
      n_total++;
      if (obs_m[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mis step %0d: got %b want 0", k, obs_m[k]);
      end
    end
  endtask

  task automatic test_train();
    add_seq(32'h4000_0010, 1'b1);
    add_seq(32'h4000_0010, 1'b1);
    for (int n = 0; n < 4; n++) add_seq(32'h4000_0010, 1'b0);
    add_seq(32'h4000_0010, 1'b1);
    add(1'b0, 1'b0, 32'h4000_0010, BR, 1'b0, 1'b0, 32'h0);
    play();
    for (int k = 0; k < obs_p.size(); k++) begin
      n_total++;
      if (obs_p[k] !== exp_p[k]) begin
        n_bad++;
        $display("FAIL train_pred step %0d: got %b want %b", k, obs_p[k], exp_p[k]);
      end
      n_total++;
      if (obs_m[k] !== exp_m[k]) begin
        n_bad++;
        $display("FAIL train_mis step %0d: got %b want %b", k, obs_m[k], exp_m[k]);
      end
    end
    n_total++;
    if (obs_p[0] !== 1'b0) begin
      n_bad++; $display("FAIL train_first_fetch: got %b want 0", obs_p[0]);
    end
    n_total++;
    if (obs_p[6] !== 1'b1) begin
      n_bad++; $display("FAIL train_after_two_taken: got %b want 1", obs_p[6]);
    end
    n_total++;
    if (obs_p[18] !== 1'b0) begin
      n_bad++; $display("FAIL train_saturated_low: got %b want 0", obs_p[18]);
    end
    n_total++;
    if (obs_p[21] !== 1'b0) begin
      n_bad++; $display("FAIL train_no_underflow: got %b want 0", obs_p[21]);
    end
  endtask

  task automatic test_mispredict_taken();
    add_seq(32'h4000_0020, 1'b1);
    add_seq(32'h4000_0020, 1'b1);
    add(1'b0, 1'b0, 32'h4000_0020, BR,  1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h4000_0024, BR,  1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h4000_0030, BR,  1'b1, 1'b0, TGT);
    add(1'b0, 1'b0, 32'h4000_0034, NOP, 1'b1, 1'b1, TGT);
    add(1'b0, 1'b0, 32'h4000_0038, NOP, 1'b1, 1'b1, TGT);
    play();
    for (int k = 0; k < obs_p.size(); k++) begin
      n_total++;
      if (obs_p[k] !== exp_p[k]) begin
        n_bad++;
        $display("FAIL mpt_pred step %0d: got %b want %b", k, obs_p[k], exp_p[k]);
      end
      n_total++;
      if (obs_m[k] !== exp_m[k]) begin
        n_bad++;
        $display("FAIL mpt_mis step %0d: got %b want %b", k, obs_m[k], exp_m[k]);
      end
    end
    n_total++;
    if (obs_p[6] !== 1'b1) begin
      n_bad++; $display("FAIL mpt_pred_taken: got %b want 1", obs_p[6]);
    end
    n_total++;
    if (obs_m[8] !== 1'b1 || obs_r[8] !== 32'h4000_0024) begin
      n_bad++;
      $display("FAIL mpt_restore: got mis=%b addr=%h want mis=1 addr=40000024", obs_m[8], obs_r[8]);
    end
    n_total++;
    if (obs_m[9] !== 1'b0 || obs_m[10] !== 1'b0) begin
      n_bad++;
      $display("FAIL mpt_flush: got mis=%b,%b want 0,0", obs_m[9], obs_m[10]);
    end
  endtask

  task automatic test_mispredict_not_taken();
    add_seq(32'h4000_0040, 1'b1);
    play();
    n_total++;
    if (obs_p[0] !== 1'b0) begin
      n_bad++; $display("FAIL mpn_pred: got %b want 0", obs_p[0]);
    end
    n_total++;
    if (obs_m[2] !== 1'b1 || obs_r[2] !== TGT) begin
      n_bad++;
      $display("FAIL mpn_restore: got mis=%b addr=%h want mis=1 addr=%h", obs_m[2], obs_r[2], TGT);
    end
  endtask

  task automatic test_stall();
    add(1'b0, 1'b0, 32'h4000_0050, BR,  1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h4000_0054, NOP, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 3; n++) add(1'b0, 1'b1, 32'h4000_0020, BR, 1'b0, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h4000_0058, NOP, 1'b1, 1'b1, TGT);
    play();
    for (int k = 2; k < 5; k++) begin
      n_total++;
      if (obs_p[k] !== 1'b0) begin
        n_bad++; $display("FAIL stall_pred step %0d: got %b want 0", k, obs_p[k]);
      end
    end
    n_total++;
    if (obs_m[5] !== 1'b1 || obs_r[5] !== TGT) begin
      n_bad++;
      $display("FAIL stall_release: got mis=%b addr=%h want mis=1 addr=%h", obs_m[5], obs_r[5], TGT);
    end
  endtask

  task automatic test_random();
    logic [31:0] p;
    for (int n = 0; n < 800; n++) begin
      p = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                      : 32'h4000_0000 + 32'(4 * $urandom_range(0, 15));
      add(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0), p,
          ($urandom_range(0, 9) < 6) ? BR : NOP,
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), $urandom);
    end
    play();
    for (int k = 0; k < obs_p.size(); k++) begin
      n_total++;
      if (obs_p[k] !== exp_p[k]) begin
        n_bad++;
        $display("FAIL rand_pred step %0d: got %b want %b", k, obs_p[k], exp_p[k]);
      end
      n_total++;
      if (obs_m[k] !== exp_m[k]) begin
        n_bad++;
        $display("FAIL rand_mis step %0d: got %b want %b", k, obs_m[k], exp_m[k]);
      end
      if (exp_m[k] === 1'b1) begin
        n_total++;
        if (obs_r[k] !== exp_r[k]) begin
          n_bad++;
          $display("FAIL rand_restore step %0d: got %h want %h", k, obs_r[k], exp_r[k]);
        end
      end
    end
`ifdef BP_STATS_EN
    n_total++;
    if (stat_branches !== sb_m || stat_mispred !== sm_m) begin
      n_bad++;
      $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", stat_branches, stat_mispred, sb_m, sm_m);
    end
`endif
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    add(1'b1, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 32'h0);
    add_seq(32'h4000_0060, 1'b1);
    add_seq(32'h4000_0060, 1'b1);
    add_seq(32'h4000_0060, 1'b1);
    add_seq(32'h4000_0060, 1'b0);
    add_seq(32'h4000_0060, 1'b1);
    play();
    n_total++;
    if (stat_branches !== 32'd5 || stat_mispred !== 32'd2) begin
      n_bad++;
      $display("FAIL stats_count: got %0d/%0d want 5/2", stat_branches, stat_mispred);
    end
    add(1'b1, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 32'h0);
    play();
    n_total++;
    if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
      n_bad++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_branches, stat_mispred);
    end
  endtask
`endif

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_train();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_stall();
    test_random();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
